bandai2003_unlock_host: RTL and testbench

//  Console-side partner of the BANDAI2003 cart mapper. On START it drives the
//  two-step address unlock sequence (5Ah, A5h) onto the cart address bus, then

---
 rtl/bandai2003_pkg.sv | 22 ++
 rtl/bandai2003_unlock_host_if.sv | 20 ++
 rtl/bandai2003_serial_rx.sv | 67 ++++++
 rtl/bandai2003_unlock_host.sv | 134 +++++++++++++
 tb/tb_bandai2003_unlock_host.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bandai2003_pkg.sv
// Shared constants and FSM state encoding for the BANDAI2003 unlock handshake,
// used by both the console-side host and the cart-side mapper.
package bandai2003_pkg;

  localparam logic [7:0]  ADDR_ACK       = 8'h5A;
  localparam logic [7:0]  ADDR_NAK       = 8'hA5;
  localparam logic [7:0]  ADDR_NIH       = 8'hFF;
  localparam logic [15:0] UNLOCK_PATTERN = 16'h28A0;
  localparam int          FRAME_BITS     = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACK  = 3'd1,
    NAK  = 3'd2,
    WAIT = 3'd3,
    DATA = 3'd4,
    STOP = 3'd5,
    DONE = 3'd6,
    FAIL = 3'd7
  } state_t;

endpackage

// File: rtl/bandai2003_unlock_host_if.sv
// Console <-> unlock host signal bundle. Names are from the host's viewpoint:
// the host uses the slave modport, whoever drives START/SI uses master.
interface bandai2003_unlock_host_if;
  logic       i_start;
  logic       i_si;
  logic [7:0] o_addr;
  logic       o_busy;
  logic       o_unlocked;
  logic       o_fail;

  modport master (
    output i_start, i_si,
    input  o_addr, o_busy, o_unlocked, o_fail
  );

  modport slave (
    input  i_start, i_si,
    output o_addr, o_busy, o_unlocked, o_fail
  );
endinterface

// File: rtl/bandai2003_serial_rx.sv
// Receive datapath for the cart SO stream: start detect, start-bit timeout,
// 16-bit LSB-first shifter and stop/pattern check, steered by the host state.
module bandai2003_serial_rx
  import bandai2003_pkg::*;
#(
  parameter logic [15:0] PATTERN = UNLOCK_PATTERN,
  parameter int          TIMEOUT = 32
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  state_t i_state,
  input  logic   i_si,
  output logic   o_start_det,
  output logic   o_data_last,
  output logic   o_frame_ok,
  output logic   o_frame_bad
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_bitcnt;
  logic [15:0]   r_shreg;

  logic w_in_wait;
  logic w_in_data;
  logic w_in_stop;
  logic w_timeout;
  logic w_stop_good;

  // Outputs are combinational so the parent FSM acts on the same edge that samples SI.
  always_comb begin
    w_in_wait   = (i_state == WAIT);
    w_in_data   = (i_state == DATA);
    w_in_stop   = (i_state == STOP);
    w_timeout   = w_in_wait & i_si & (r_tcnt == TW'(TIMEOUT - 1));
    w_stop_good = w_in_stop & ~i_si & (r_shreg == PATTERN);
    o_start_det = w_in_wait & ~i_si;
    o_data_last = w_in_data & (r_bitcnt == 4'd15);
    o_frame_ok  = w_stop_good;
    o_frame_bad = w_timeout | (w_in_stop & ~w_stop_good);
  end

  // Counters only run inside their own phase, so they never exceed their range.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tcnt   <= '0;
      r_bitcnt <= 4'd0;
      r_shreg  <= 16'h0000;
    end else begin
      if (w_in_wait && i_si) begin
        r_tcnt <= r_tcnt + TW'(1);
      end else begin
        r_tcnt <= '0;
      end

      if (w_in_data) begin
        r_bitcnt <= r_bitcnt + 4'd1;
        r_shreg  <= {i_si, r_shreg[15:1]};
      end else begin
        r_bitcnt <= 4'd0;
        r_shreg  <= r_shreg;
      end
    end
  end

endmodule

// File: rtl/bandai2003_unlock_host.sv
// Console-side BANDAI2003 unlock host: sends the 5Ah/A5h address unlock,
// receives and checks the cart's reply frame, retries, and reports the result.
module bandai2003_unlock_host
  import bandai2003_pkg::*;
#(
  parameter logic [7:0]  IDLE_ADDR = ADDR_NIH,
  parameter logic [15:0] PATTERN   = UNLOCK_PATTERN,
  parameter int          TIMEOUT   = 32,
  parameter int          ATTEMPTS  = 3
) (
  input logic                     i_clk,
  input logic                     i_rst,
  bandai2003_unlock_host_if.slave bus
);

  localparam int AW = $clog2(ATTEMPTS + 1);

  state_t        r_state;
  logic [AW-1:0] r_attempt;
  logic [7:0]    r_addr;
  logic          r_busy;
  logic          r_unlocked;
  logic          r_fail;

  logic          w_start_det;
  logic          w_data_last;
  logic          w_frame_ok;
  logic          w_frame_bad;
  logic [AW-1:0] w_attempt_nxt;
  logic          w_retry;

  bandai2003_serial_rx #(
    .PATTERN (PATTERN),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_state     (r_state),
    .i_si        (bus.i_si),
    .o_start_det (w_start_det),
    .o_data_last (w_data_last),
    .o_frame_ok  (w_frame_ok),
    .o_frame_bad (w_frame_bad)
  );

  // The attempt counter stops at ATTEMPTS because reaching it leaves the retry loop.
  always_comb begin
    w_attempt_nxt = r_attempt + AW'(1);
    w_retry       = (w_attempt_nxt < AW'(ATTEMPTS));
  end

  // Unlock sequencer; every output is updated on the transition that selects it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_attempt  <= '0;
      r_addr     <= IDLE_ADDR;
      r_busy     <= 1'b0;
      r_unlocked <= 1'b0;
      r_fail     <= 1'b0;
    end else if (w_frame_bad) begin
      r_attempt <= w_attempt_nxt;
      if (w_retry) begin
        // Resending the unlock pair also resynchronises a cart stuck mid-sequence.
        r_state <= ACK;
        r_addr  <= ADDR_ACK;
      end else begin
        r_state <= FAIL;
        r_addr  <= IDLE_ADDR;
        r_busy  <= 1'b0;
        r_fail  <= 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_state   <= ACK;
            r_attempt <= '0;
            r_addr    <= ADDR_ACK;
            r_busy    <= 1'b1;
          end
        end
        ACK: begin
          r_state <= NAK;
          r_addr  <= ADDR_NAK;
        end
        NAK: begin
          r_state <= WAIT;
          r_addr  <= IDLE_ADDR;
        end
        WAIT: begin
          if (w_start_det) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_data_last) begin
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_frame_ok) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_unlocked <= 1'b1;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        FAIL: begin
          if (bus.i_start) begin
            r_state   <= ACK;
            r_attempt <= '0;
            r_addr    <= ADDR_ACK;
            r_busy    <= 1'b1;
            r_fail    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_addr  <= IDLE_ADDR;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_addr     = r_addr;
  assign bus.o_busy     = r_busy;
  assign bus.o_unlocked = r_unlocked;
  assign bus.o_fail     = r_fail;

endmodule

// File: tb/tb_bandai2003_unlock_host.sv
// Bench for bandai2003_unlock_host paired with a simple BANDAI2003 cart model;
// per-cycle expected bus values are queued and compared on the falling edge.
module tb_bandai2003_unlock_host;

  typedef struct packed {
    logic [7:0] addr;
    logic       busy;
    logic       unl;
    logic       fail;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bandai2003_unlock_host_if bus ();

  bandai2003_unlock_host u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // cart model configuration
  logic        cart_rst = 1'b1;
  logic        cart_en  = 1'b1;
  logic        stop_bit = 1'b0;
  logic [15:0] pay [3];

  logic [17:0] m_shift;
  logic [4:0]  m_left;
  logic [7:0]  m_prev;
  int          m_loads;

  // cart: loads {stop, payload, start} when it sees 5Ah then A5h, shifts LSB first
  always @(posedge clk) begin
    if (cart_rst) begin
      m_shift <= 18'd0;
      m_left  <= 5'd0;
      m_prev  <= 8'hFF;
      m_loads <= 0;
    end else begin
      m_prev <= bus.o_addr;
      if (cart_en && m_prev == 8'h5A && bus.o_addr == 8'hA5) begin
        m_shift <= {stop_bit, pay[(m_loads > 2) ? 2 : m_loads], 1'b0};
        m_left  <= 5'd18;
        m_loads <= m_loads + 1;
      end else if (m_left != 5'd0) begin
        m_shift <= m_shift >> 1;
        m_left  <= m_left - 5'd1;
      end
    end
  end

  assign bus.i_si = (m_left != 5'd0) ? m_shift[0] : 1'b1;

  exp_t sbq[$];
  exp_t e;
  exp_t act;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc;

  task automatic push(input logic [7:0] a, input logic b, input logic u,
                      input logic f, input int n);
    for (int k = 0; k < n; k++) sbq.push_back({a, b, u, f});
  endtask

  task automatic push_unlock_ok();
    push(8'h5A, 1'b1, 1'b0, 1'b0, 1);
    push(8'hA5, 1'b1, 1'b0, 1'b0, 1);
    push(8'hFF, 1'b1, 1'b0, 1'b0, 18);
    push(8'hFF, 1'b0, 1'b1, 1'b0, 3);
  endtask

  task automatic do_reset();
    bus.i_start = 1'b0;
    rst = 1'b1;
    cart_rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cart_rst = 1'b0;
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0;
    rst = 1'b1;
    cart_rst = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.o_addr !== 8'hFF) $display("FAIL rst_addr: got %h want ff", bus.o_addr); else n_pass++;
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.o_busy); else n_pass++;
    n_chk++; if (bus.o_unlocked !== 1'b0) $display("FAIL rst_unl: got %b want 0", bus.o_unlocked); else n_pass++;
    n_chk++; if (bus.o_fail !== 1'b0) $display("FAIL rst_fail: got %b want 0", bus.o_fail); else n_pass++;
  endtask

  task automatic test_unlock();
    cart_en = 1'b1; stop_bit = 1'b0;
    pay[0] = 16'h28A0; pay[1] = 16'h28A0; pay[2] = 16'h28A0;
    do_reset();
    pulse_start();
    push_unlock_ok();
    cyc = 1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = {bus.o_addr, bus.o_busy, bus.o_unlocked, bus.o_fail};
      n_chk++;
      if (act !== e) $display("FAIL unlock cyc%0d: got %h want %h", cyc, act, e); else n_pass++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    cart_en = 1'b0; stop_bit = 1'b0;
    do_reset();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      push(8'h5A, 1'b1, 1'b0, 1'b0, 1);
      push(8'hA5, 1'b1, 1'b0, 1'b0, 1);
      push(8'hFF, 1'b1, 1'b0, 1'b0, 32);
    end
    push(8'hFF, 1'b0, 1'b0, 1'b1, 3);
    cyc = 1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = {bus.o_addr, bus.o_busy, bus.o_unlocked, bus.o_fail};
      n_chk++;
      if (act !== e) $display("FAIL timeout cyc%0d: got %h want %h", cyc, act, e); else n_pass++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_retry();
    cart_en = 1'b1; stop_bit = 1'b0;
    pay[0] = 16'h28A1; pay[1] = 16'h28A0; pay[2] = 16'h28A0;
    do_reset();
    pulse_start();
    push(8'h5A, 1'b1, 1'b0, 1'b0, 1);
    push(8'hA5, 1'b1, 1'b0, 1'b0, 1);
    push(8'hFF, 1'b1, 1'b0, 1'b0, 18);
    push_unlock_ok();
    cyc = 1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = {bus.o_addr, bus.o_busy, bus.o_unlocked, bus.o_fail};
      n_chk++;
      if (act !== e) $display("FAIL retry cyc%0d: got %h want %h", cyc, act, e); else n_pass++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_bad_stop();
    cart_en = 1'b1; stop_bit = 1'b1;
    pay[0] = 16'h28A0; pay[1] = 16'h28A0; pay[2] = 16'h28A0;
    do_reset();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      push(8'h5A, 1'b1, 1'b0, 1'b0, 1);
      push(8'hA5, 1'b1, 1'b0, 1'b0, 1);
      push(8'hFF, 1'b1, 1'b0, 1'b0, 18);
    end
    push(8'hFF, 1'b0, 1'b0, 1'b1, 3);
    cyc = 1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = {bus.o_addr, bus.o_busy, bus.o_unlocked, bus.o_fail};
      n_chk++;
      if (act !== e) $display("FAIL badstop cyc%0d: got %h want %h", cyc, act, e); else n_pass++;
      cyc++;
      @(negedge clk);
    end
    // restart out of the failed state
    pulse_start();
    push(8'h5A, 1'b1, 1'b0, 1'b0, 1);
    push(8'hA5, 1'b1, 1'b0, 1'b0, 1);
    cyc = 1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = {bus.o_addr, bus.o_busy, bus.o_unlocked, bus.o_fail};
      n_chk++;
      if (act !== e) $display("FAIL restart cyc%0d: got %h want %h", cyc, act, e); else n_pass++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    cart_en = 1'b1; stop_bit = 1'b0;
    pay[0] = 16'h28A0; pay[1] = 16'h28A0; pay[2] = 16'h28A0;
    do_reset();
    pulse_start();
    push(8'h5A, 1'b1, 1'b0, 1'b0, 1);
    push(8'hA5, 1'b1, 1'b0, 1'b0, 1);
    push(8'hFF, 1'b1, 1'b0, 1'b0, 10);
    cyc = 1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = {bus.o_addr, bus.o_busy, bus.o_unlocked, bus.o_fail};
      n_chk++;
      if (act !== e) $display("FAIL pre_rst cyc%0d: got %h want %h", cyc, act, e); else n_pass++;
      cyc++;
      @(negedge clk);
    end
    // data bit 8 was sampled at the last edge; reset mid-cycle
    rst = 1'b1;
    cart_rst = 1'b1;
    #1;
    act = {bus.o_addr, bus.o_busy, bus.o_unlocked, bus.o_fail};
    n_chk++;
    if (act !== {8'hFF, 1'b0, 1'b0, 1'b0}) $display("FAIL async_rst: got %h want %h", act, {8'hFF, 3'b000}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    cart_rst = 1'b0;
    @(negedge clk);
    pulse_start();
    push_unlock_ok();
    cyc = 1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = {bus.o_addr, bus.o_busy, bus.o_unlocked, bus.o_fail};
      n_chk++;
      if (act !== e) $display("FAIL post_rst cyc%0d: got %h want %h", cyc, act, e); else n_pass++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_start_held();
    cart_en = 1'b1; stop_bit = 1'b0;
    pay[0] = 16'h28A0; pay[1] = 16'h28A0; pay[2] = 16'h28A0;
    do_reset();
    bus.i_start = 1'b1;
    @(negedge clk);
    push_unlock_ok();
    push(8'hFF, 1'b0, 1'b1, 1'b0, 10);
    cyc = 1;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      act = {bus.o_addr, bus.o_busy, bus.o_unlocked, bus.o_fail};
      n_chk++;
      if (act !== e) $display("FAIL held cyc%0d: got %h want %h", cyc, act, e); else n_pass++;
      cyc++;
      @(negedge clk);
    end
    bus.i_start = 1'b0;
  endtask

  initial begin
    bus.i_start = 1'b0;
    pay[0] = 16'h28A0; pay[1] = 16'h28A0; pay[2] = 16'h28A0;
    test_reset();
    test_unlock();
    test_timeout();
    test_retry();
    test_bad_stop();
    test_mid_reset();
    test_start_held();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
